wb_stage: RTL and testbench

- Writeback pipeline stage. Takes the retiring instruction's result from the memory stage and produces the register-file write port consumed by decode: RegWrite, RAddr and RData.
- Formats load data (byte/half/word, signed/unsigned, big-endian).
- Holds the pipeline with a stall when load data arrives late on a valid/ready-style memory response.

---
 rtl/wb_stage.sv | 202 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback pipeline stage
//
// Accepts the retiring instruction from the memory stage and drives the
// register-file write port. Load data is formatted here: byte, halfword or
// word, signed or unsigned, big-endian. When the memory response arrives
// late, the stage parks the load in WAIT_MEM and stalls upstream.
//
// Optional feature: define WB_TIMEOUT_EN to give up on a load after TIMEOUT
// WAIT_MEM cycles. The stage then returns to IDLE, drops the write and
// pulses MemErr for one cycle. When the macro is undefined there is no
// timeout and MemErr is tied 0.
//
// Ports
//   Clock        in   system clock, rising edge
//   nReset       in   asynchronous active-low reset
//   Valid        in   an instruction is present from the memory stage
//   RegWriteIn   in   the instruction writes a register
//   MemtoReg     in   the result comes from memory (a load)
//   RAddrIn      in   [4:0]  destination register
//   ALUOut       in   [31:0] ALU/MUL result
//   Memfunc      in   [2:0]  000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU;
//                            any other code behaves as LW
//   ByteSel      in   [1:0]  load address bits [1:0]
//   MemData      in   [31:0] memory read word
//   MemValid     in   MemData is valid this cycle
//   RegWriteOut  out  register-file write enable (registered)
//   RAddrOut     out  [4:0]  register-file write address (registered)
//   RDataOut     out  [31:0] register-file write data (registered)
//   Stall        out  freeze upstream stages (combinational)
//   MemErr       out  one-cycle pulse when a load times out
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Valid,
    input  logic        RegWriteIn,
    input  logic        MemtoReg,
    input  logic [4:0]  RAddrIn,
    input  logic [31:0] ALUOut,
    input  logic [2:0]  Memfunc,
    input  logic [1:0]  ByteSel,
    input  logic [31:0] MemData,
    input  logic        MemValid,
    output logic        RegWriteOut,
    output logic [4:0]  RAddrOut,
    output logic [31:0] RDataOut,
    output logic        Stall,
    output logic        MemErr
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t      state, state_d;

    // Fields of a load that is waiting for its memory response.
    logic        hold_we;
    logic [4:0]  hold_addr;
    logic [2:0]  hold_func;
    logic [1:0]  hold_sel;

    // Next values of the registered outputs.
    logic        we_d;
    logic [4:0]  addr_d;
    logic [31:0] data_d;
    logic        err_d;
    logic        capture;
    logic        timeout_hit;

    // Big-endian load formatting: ByteSel 0 is the most significant byte.
    function automatic logic [31:0] fmt_load(input logic [2:0]  func,
                                             input logic [1:0]  sel,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = sel[1] ? word[15:0] : word[31:16];
        case (func)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = word;
        endcase
    endfunction

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // A response arriving on the last allowed cycle still wins.
    assign timeout_hit = (state == WAIT_MEM) && !MemValid &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wait_cnt <= '0;
        end else if (capture) begin
            wait_cnt <= '0;
        end else if (state == WAIT_MEM) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    // State, holding fields and output registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    // NOTE: the holding fields are reset too, so a load pending when reset
    // hits is fully discarded rather than relying on the state alone.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            hold_we     <= 1'b0;
            hold_addr   <= '0;
            hold_func   <= '0;
            hold_sel    <= '0;
            RegWriteOut <= 1'b0;
            RAddrOut    <= '0;
            RDataOut    <= '0;
            MemErr      <= 1'b0;
        end else begin
            state       <= state_d;
            RegWriteOut <= we_d;
            RAddrOut    <= addr_d;
            RDataOut    <= data_d;
            MemErr      <= err_d;
            if (capture) begin
                hold_we   <= RegWriteIn;
                hold_addr <= RAddrIn;
                hold_func <= Memfunc;
                hold_sel  <= ByteSel;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (Valid && MemtoReg && !MemValid) state_d = WAIT_MEM;
            WAIT_MEM: if (MemValid || timeout_hit)       state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output next-value logic.
    // NOTE: every signal gets a default before the case so no latch is
    // inferred; address and data default to holding their current value.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = RAddrOut;
        data_d  = RDataOut;
        err_d   = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (Valid) begin
                    if (!MemtoReg) begin
                        we_d   = RegWriteIn;
                        addr_d = RAddrIn;
                        data_d = ALUOut;
                    end else if (MemValid) begin
                        we_d   = RegWriteIn;
                        addr_d = RAddrIn;
                        data_d = fmt_load(Memfunc, ByteSel, MemData);
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (MemValid) begin
                    we_d   = hold_we;
                    addr_d = hold_addr;
                    data_d = fmt_load(hold_func, hold_sel, MemData);
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
        // Register 0 is never written, but address and data still track.
        if (addr_d == 5'd0) we_d = 1'b0;
    end

    assign Stall = ((state == WAIT_MEM) && !MemValid && !timeout_hit) ||
                   ((state == IDLE) && Valid && MemtoReg && !MemValid);

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage
//
// Inputs are driven 1 time unit after the rising edge; the combinational
// Stall is checked in the same cycle and the registered outputs are checked
// 1 time unit after the following edge. Define WB_TIMEOUT_EN for both bench
// and RTL to exercise the load timeout with TIMEOUT=4.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        Valid;
    logic        RegWriteIn;
    logic        MemtoReg;
    logic [4:0]  RAddrIn;
    logic [31:0] ALUOut;
    logic [2:0]  Memfunc;
    logic [1:0]  ByteSel;
    logic [31:0] MemData;
    logic        MemValid;
    logic        RegWriteOut;
    logic [4:0]  RAddrOut;
    logic [31:0] RDataOut;
    logic        Stall;
    logic        MemErr;

    int total = 0;
    int bad   = 0;

    wb_stage #(.TIMEOUT(4)) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .Valid       (Valid),
        .RegWriteIn  (RegWriteIn),
        .MemtoReg    (MemtoReg),
        .RAddrIn     (RAddrIn),
        .ALUOut      (ALUOut),
        .Memfunc     (Memfunc),
        .ByteSel     (ByteSel),
        .MemData     (MemData),
        .MemValid    (MemValid),
        .RegWriteOut (RegWriteOut),
        .RAddrOut    (RAddrOut),
        .RDataOut    (RDataOut),
        .Stall       (Stall),
        .MemErr      (MemErr)
    );

    always #5 Clock = ~Clock;

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_idle();
        Valid      = 1'b0;
        RegWriteIn = 1'b0;
        MemtoReg   = 1'b0;
        RAddrIn    = 5'd0;
        ALUOut     = 32'd0;
        Memfunc    = 3'b011;
        ByteSel    = 2'd0;
        MemData    = 32'd0;
        MemValid   = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        nReset = 1'b0;
        #12;
        total++;
        if ({RegWriteOut, RAddrOut, RDataOut, MemErr, Stall} !== 40'd0) begin
            bad++;
            $display("FAIL reset_outputs got we=%b addr=%0d data=%h err=%b stall=%b want all 0",
                     RegWriteOut, RAddrOut, RDataOut, MemErr, Stall);
        end
        @(negedge Clock);
        nReset = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu();
        Valid = 1'b1; RegWriteIn = 1'b1; MemtoReg = 1'b0;
        RAddrIn = 5'd5; ALUOut = 32'h1234_5678;
        #1;
        total++;
        if (Stall !== 1'b0) begin
            bad++; $display("FAIL alu_stall got=%b want=0", Stall);
        end
        next_cycle();
        drive_idle();
        total++;
        if ({RegWriteOut, RAddrOut, RDataOut} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            bad++;
            $display("FAIL alu_write got we=%b addr=%0d data=%h want we=1 addr=5 data=12345678",
                     RegWriteOut, RAddrOut, RDataOut);
        end
        next_cycle();
        total++;
        if ({RegWriteOut, RAddrOut, RDataOut} !== {1'b0, 5'd5, 32'h1234_5678}) begin
            bad++;
            $display("FAIL idle_hold got we=%b addr=%0d data=%h want we=0 addr=5 data=12345678",
                     RegWriteOut, RAddrOut, RDataOut);
        end
    endtask

    task automatic test_r0();
        Valid = 1'b1; RegWriteIn = 1'b1; MemtoReg = 1'b0;
        RAddrIn = 5'd0; ALUOut = 32'hA5A5_0F0F;
        next_cycle();
        drive_idle();
        total++;
        if ({RegWriteOut, RAddrOut, RDataOut} !== {1'b0, 5'd0, 32'hA5A5_0F0F}) begin
            bad++;
            $display("FAIL r0_suppress got we=%b addr=%0d data=%h want we=0 addr=0 data=a5a50f0f",
                     RegWriteOut, RAddrOut, RDataOut);
        end
    endtask

    task automatic test_load_fmt();
        logic [2:0]  f_tab [8];
        logic [1:0]  s_tab [8];
        logic [31:0] e_tab [8];
        f_tab[0] = 3'b000; s_tab[0] = 2'd0; e_tab[0] = 32'hFFFF_FF80; // LB
        f_tab[1] = 3'b100; s_tab[1] = 2'd0; e_tab[1] = 32'h0000_0080; // LBU
        f_tab[2] = 3'b001; s_tab[2] = 2'd2; e_tab[2] = 32'h0000_7F01; // LH
        f_tab[3] = 3'b101; s_tab[3] = 2'd0; e_tab[3] = 32'h0000_80FF; // LHU
        f_tab[4] = 3'b011; s_tab[4] = 2'd1; e_tab[4] = 32'h80FF_7F01; // LW
        f_tab[5] = 3'b000; s_tab[5] = 2'd3; e_tab[5] = 32'h0000_0001; // LB low byte
        f_tab[6] = 3'b001; s_tab[6] = 2'd1; e_tab[6] = 32'hFFFF_80FF; // LH, ByteSel[0] ignored
        f_tab[7] = 3'b010; s_tab[7] = 2'd3; e_tab[7] = 32'h80FF_7F01; // unknown code acts as LW
        for (int i = 0; i < 8; i++) begin
            Valid = 1'b1; RegWriteIn = 1'b1; MemtoReg = 1'b1;
            RAddrIn = 5'(10 + i); Memfunc = f_tab[i]; ByteSel = s_tab[i];
            MemData = 32'h80FF_7F01; MemValid = 1'b1;
            next_cycle();
            total++;
            if ({RegWriteOut, RAddrOut, RDataOut} !== {1'b1, 5'(10 + i), e_tab[i]}) begin
                bad++;
                $display("FAIL load_fmt[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         i, RegWriteOut, RAddrOut, RDataOut, 10 + i, e_tab[i]);
            end
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_late_load();
        Valid = 1'b1; RegWriteIn = 1'b1; MemtoReg = 1'b1;
        RAddrIn = 5'd9; Memfunc = 3'b011; ByteSel = 2'd0; MemValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({Stall, RegWriteOut, MemErr} !== 3'b100) begin
                bad++;
                $display("FAIL late_wait[%0d] got stall=%b we=%b err=%b want stall=1 we=0 err=0",
                         i, Stall, RegWriteOut, MemErr);
            end
            next_cycle();
            // Upstream inputs are ignored while waiting; drive junk.
            Valid = 1'b1; MemtoReg = 1'b0; RAddrIn = 5'd3; ALUOut = 32'h0000_0BAD;
        end
        MemValid = 1'b1; MemData = 32'hDEAD_BEEF;
        RAddrIn = 5'd12; ALUOut = 32'hCAFE_0001; RegWriteIn = 1'b1;
        #1;
        total++;
        if (Stall !== 1'b0) begin
            bad++; $display("FAIL late_stall_drop got=%b want=0", Stall);
        end
        next_cycle();
        MemValid = 1'b0;
        total++;
        if ({RegWriteOut, RAddrOut, RDataOut, Stall} !== {1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0}) begin
            bad++;
            $display("FAIL late_write got we=%b addr=%0d data=%h stall=%b want we=1 addr=9 data=deadbeef stall=0",
                     RegWriteOut, RAddrOut, RDataOut, Stall);
        end
        next_cycle();
        drive_idle();
        total++;
        if ({RegWriteOut, RAddrOut, RDataOut} !== {1'b1, 5'd12, 32'hCAFE_0001}) begin
            bad++;
            $display("FAIL back_to_back got we=%b addr=%0d data=%h want we=1 addr=12 data=cafe0001",
                     RegWriteOut, RAddrOut, RDataOut);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        Valid = 1'b1; RegWriteIn = 1'b1; MemtoReg = 1'b1;
        RAddrIn = 5'd4; Memfunc = 3'b011; MemValid = 1'b0;
        next_cycle();
        Valid = 1'b0;
        total++;
        if (Stall !== 1'b1) begin
            bad++; $display("FAIL rst_wait_stall got=%b want=1", Stall);
        end
        #2;
        nReset = 1'b0;
        #1;
        total++;
        if ({RegWriteOut, RAddrOut, RDataOut, MemErr, Stall} !== 40'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs got we=%b addr=%0d data=%h err=%b stall=%b want all 0",
                     RegWriteOut, RAddrOut, RDataOut, MemErr, Stall);
        end
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        MemValid = 1'b1; MemData = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            total++;
            if ({RegWriteOut, RAddrOut, RDataOut} !== 38'd0) begin
                bad++;
                $display("FAIL rst_no_write[%0d] got we=%b addr=%0d data=%h want we=0 addr=0 data=0",
                         i, RegWriteOut, RAddrOut, RDataOut);
            end
        end
        drive_idle();
        next_cycle();
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        Valid = 1'b1; RegWriteIn = 1'b1; MemtoReg = 1'b1;
        RAddrIn = 5'd6; Memfunc = 3'b011; MemValid = 1'b0;
        // Cycles 0-3 stall, cycle 4 is the timeout cycle, MemErr shows in 5.
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                Valid = 1'b1; MemtoReg = 1'b0; RAddrIn = 5'd2; ALUOut = 32'h0000_0042;
            end
            #1;
            total++;
            if ({Stall, MemErr, RegWriteOut} !== {(i < 4), (i == 5), 1'b0}) begin
                bad++;
                $display("FAIL timeout[%0d] got stall=%b err=%b we=%b want stall=%b err=%b we=0",
                         i, Stall, MemErr, RegWriteOut, (i < 4), (i == 5));
            end
            next_cycle();
            if (i == 0) Valid = 1'b0;
        end
        drive_idle();
        total++;
        if ({MemErr, RegWriteOut, RAddrOut, RDataOut} !== {1'b0, 1'b1, 5'd2, 32'h0000_0042}) begin
            bad++;
            $display("FAIL timeout_recover got err=%b we=%b addr=%0d data=%h want err=0 we=1 addr=2 data=42",
                     MemErr, RegWriteOut, RAddrOut, RDataOut);
        end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_r0();
        test_load_fmt();
        test_late_load();
        test_reset_mid_wait();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
